// File: rtl/opcode_decoder.sv
// opcode_decoder
// Consumer end of the keypad opcode path. Latches a pending add/subtract
// operation from the encoder strobe and waits for an enter strobe. It then
// issues the operation to the matrix ALU over a start/busy/done handshake and
// requests result display on completion. A watchdog aborts a stalled
// handshake. Every output is registered.
//
// Build option: define OPCODE_DECODER_QUEUE_EN to add a one-entry queue. The
// queue holds a strobe that arrives while an operation is in flight and
// replays it once the decoder returns to IDLE.

module opcode_decoder #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [2:0] opcode,
  input  logic       is_op,
  input  logic       is_result,
  input  logic       is_enter,
  input  logic       alu_busy,
  input  logic       alu_done,
  output logic       alu_start,
  output logic [1:0] alu_sel,
  output logic       op_pending,
  output logic       disp_result,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Latched operation: ALU select code and "produces a displayable result".
  logic [1:0] sel_q, sel_d;
  logic       res_q, res_d;

  // Watchdog counting cycles spent in WAIT.
  logic [CNT_W-1:0] wdog_q, wdog_d, wdogInc;

  // Registered output stages.
  logic       aluStart_q, aluStart_d;
  logic [1:0] aluSel_q, aluSel_d;
  logic       opPending_q, opPending_d;
  logic       dispResult_q, dispResult_d;
  logic       err_q, err_d;

  // Decoded strobe and handshake events.
  logic       opLegal;
  logic       opIllegal;
  logic [1:0] opSel;
  logic       startHit;
  logic       doneHit;
  logic       timeoutHit;
  logic       errWindow;
  logic       drainEnter;

`ifdef OPCODE_DECODER_QUEUE_EN
  // One-entry replay queue: op, result flag, enter-seen bit.
  logic       qValid_q, qValid_d;
  logic [1:0] qSel_q, qSel_d;
  logic       qRes_q, qRes_d;
  logic       qEnter_q, qEnter_d;
  logic       inFlight;
`endif

  // Classify the incoming strobe and the handshake events for this cycle.
  always_comb begin
    opLegal   = is_op && ((opcode == 3'b001) || (opcode == 3'b010));
    opIllegal = is_op && !opLegal;
    opSel     = (opcode == 3'b001) ? 2'b01 : 2'b10;
    startHit  = (state_q == ISSUE) && !alu_busy;
    doneHit   = (state_q == WAIT) && alu_done;
    // The counter saturates so that it can never wrap back to a small value.
    wdogInc   = (wdog_q >= CNT_W'(TIMEOUT_CYCLES)) ? wdog_q : wdog_q + CNT_W'(1);
    // A done arriving in the expiry cycle takes priority over the abort.
    timeoutHit = (state_q == WAIT) && !alu_done && (wdogInc == CNT_W'(TIMEOUT_CYCLES));
`ifdef OPCODE_DECODER_QUEUE_EN
    inFlight  = (state_q == ISSUE) || (state_q == WAIT) || (state_q == RESULT);
    errWindow = (state_q == IDLE) || (state_q == ARMED) || inFlight;
`else
    errWindow = (state_q == IDLE) || (state_q == ARMED);
`endif
  end

  // State register together with the latched operation, watchdog and outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      sel_q        <= 2'b00;
      res_q        <= 1'b0;
      wdog_q       <= '0;
      aluStart_q   <= 1'b0;
      aluSel_q     <= 2'b00;
      opPending_q  <= 1'b0;
      dispResult_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef OPCODE_DECODER_QUEUE_EN
      qValid_q     <= 1'b0;
      qSel_q       <= 2'b00;
      qRes_q       <= 1'b0;
      qEnter_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      res_q        <= res_d;
      wdog_q       <= wdog_d;
      aluStart_q   <= aluStart_d;
      aluSel_q     <= aluSel_d;
      opPending_q  <= opPending_d;
      dispResult_q <= dispResult_d;
      err_q        <= err_d;
`ifdef OPCODE_DECODER_QUEUE_EN
      qValid_q     <= qValid_d;
      qSel_q       <= qSel_d;
      qRes_q       <= qRes_d;
      qEnter_q     <= qEnter_d;
`endif
    end
  end

  // Next-state logic: operation latching, handshake sequencing and watchdog.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    res_d      = res_q;
    wdog_d     = wdog_q;
    drainEnter = 1'b0;
`ifdef OPCODE_DECODER_QUEUE_EN
    qValid_d   = qValid_q;
    qSel_d     = qSel_q;
    qRes_d     = qRes_q;
    qEnter_d   = qEnter_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef OPCODE_DECODER_QUEUE_EN
        if (qValid_q) begin
          // Replay the queued strobe. A fresh strobe in this cycle behaves
          // as if it had arrived in ARMED.
          sel_d      = qSel_q;
          res_d      = qRes_q;
          drainEnter = qEnter_q;
          qValid_d   = 1'b0;
          qEnter_d   = 1'b0;
          if (opLegal) begin
            sel_d      = opSel;
            res_d      = is_result;
            drainEnter = drainEnter | is_enter;
          end else if (!is_op) begin
            drainEnter = drainEnter | is_enter;
          end
          state_d = drainEnter ? ISSUE : ARMED;
        end else
`endif
        if (opLegal) begin
          sel_d   = opSel;
          res_d   = is_result;
          state_d = is_enter ? ISSUE : ARMED;
        end
      end

      ARMED: begin
        if (opLegal) begin
          sel_d = opSel;
          res_d = is_result;
          if (is_enter) state_d = ISSUE;
        end else if (!is_op && is_enter) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (startHit) begin
          wdog_d  = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        wdog_d = wdogInc;
        if (doneHit) begin
          if (res_q) begin
            state_d = RESULT;
          end else begin
            state_d = IDLE;
            sel_d   = 2'b00;
            res_d   = 1'b0;
          end
        end else if (timeoutHit) begin
          state_d = IDLE;
          sel_d   = 2'b00;
          res_d   = 1'b0;
        end
      end

      RESULT: begin
        state_d = IDLE;
        sel_d   = 2'b00;
        res_d   = 1'b0;
      end

      default: begin
        state_d = IDLE;
        sel_d   = 2'b00;
        res_d   = 1'b0;
      end
    endcase

`ifdef OPCODE_DECODER_QUEUE_EN
    // While an operation is in flight the most recent strobe goes into the
    // queue. An abort discards whatever is waiting there.
    if (timeoutHit) begin
      qValid_d = 1'b0;
      qSel_d   = 2'b00;
      qRes_d   = 1'b0;
      qEnter_d = 1'b0;
    end else if (inFlight) begin
      if (opLegal) begin
        qValid_d = 1'b1;
        qSel_d   = opSel;
        qRes_d   = is_result;
        qEnter_d = is_enter;
      end else if (!is_op && is_enter && qValid_q) begin
        qEnter_d = 1'b1;
      end
    end
`endif
  end

  // Output logic: the values every output register takes at the next edge.
  always_comb begin
    aluStart_d   = startHit;
    aluSel_d     = (state_d == WAIT) ? sel_d : 2'b00;
    opPending_d  = (state_d == ARMED) || (state_d == ISSUE);
    dispResult_d = (state_d == RESULT);
    err_d        = timeoutHit || (opIllegal && errWindow);
  end

  assign alu_start   = aluStart_q;
  assign alu_sel     = aluSel_q;
  assign op_pending  = opPending_q;
  assign disp_result = dispResult_q;
  assign err         = err_q;

endmodule

// File: tb/tb_opcode_decoder.sv
// Testbench for opcode_decoder: directed scenarios checked every cycle against
// a behavioural model, plus literal expectations at key points of each scenario.
`timescale 1ns/1ps

module tb_opcode_decoder;

  localparam int TO = 8;
`ifdef OPCODE_DECODER_QUEUE_EN
  localparam bit QUEUE_ON = 1'b1;
`else
  localparam bit QUEUE_ON = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_ARMED = 1, PH_ISSUE = 2, PH_WAIT = 3, PH_RESULT = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       is_op = 1'b0, is_result = 1'b0, is_enter = 1'b0;
  logic       alu_busy = 1'b0, alu_done = 1'b0;
  logic       alu_start, op_pending, disp_result, err;
  logic [1:0] alu_sel;

  int assertCount = 0;
  int failCount = 0;
  int startCount = 0, dispCount = 0, errCount = 0;

  // Model state and the outputs it predicts for the current cycle.
  int       mPhase = PH_IDLE;
  int       mWaited = 0;
  logic [1:0] mSel = 2'b00, mQsel = 2'b00;
  bit       mRes = 0, mQv = 0, mQres = 0, mQent = 0;
  bit       eStart = 0, ePend = 0, eDisp = 0, eErr = 0;
  logic [1:0] eSel = 2'b00;

  always #5 clk = ~clk;

  opcode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .is_op(is_op),
    .is_result(is_result), .is_enter(is_enter), .alu_busy(alu_busy),
    .alu_done(alu_done), .alu_start(alu_start), .alu_sel(alu_sel),
    .op_pending(op_pending), .disp_result(disp_result), .err(err)
  );

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Pins a DUT output and the model's prediction to the same hand-derived value.
  task automatic checkLit(input string name, input logic [3:0] actual, input logic [3:0] model, input logic [3:0] lit);
    checkOutput({name, " dut"}, actual, lit);
    checkOutput({name, " model"}, model, lit);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic op_v, input logic res, input logic ent);
    opcode = op; is_op = op_v; is_result = res; is_enter = ent;
    tick(1);
    opcode = 3'd0; is_op = 1'b0; is_result = 1'b0; is_enter = 1'b0;
  endtask

  task automatic modelReset();
    mPhase = PH_IDLE; mWaited = 0; mSel = 2'b00; mRes = 0;
    mQv = 0; mQsel = 2'b00; mQres = 0; mQent = 0;
    eStart = 0; ePend = 0; eDisp = 0; eErr = 0; eSel = 2'b00;
  endtask

  // Predicts the outputs after the coming clock edge from the inputs now present.
  task automatic modelStep();
    bit legal, illegal, ent2, expired;
    logic [1:0] newSel;
    int nxt;
    legal   = is_op && (opcode == 3'd1 || opcode == 3'd2);
    illegal = is_op && !legal;
    newSel  = (opcode == 3'd1) ? 2'b01 : 2'b10;
    eStart = 0; eErr = 0; expired = 0; ent2 = 0;
    nxt = mPhase;
    case (mPhase)
      PH_IDLE: begin
        if (mQv) begin
          mSel = mQsel; mRes = mQres; ent2 = mQent; mQv = 0; mQent = 0;
          if (illegal) eErr = 1;
          else begin
            if (legal) begin mSel = newSel; mRes = is_result; end
            ent2 = ent2 | is_enter;
          end
          nxt = ent2 ? PH_ISSUE : PH_ARMED;
        end else if (illegal) eErr = 1;
        else if (legal) begin
          mSel = newSel; mRes = is_result;
          nxt = is_enter ? PH_ISSUE : PH_ARMED;
        end
      end
      PH_ARMED: begin
        if (illegal) eErr = 1;
        else begin
          if (legal) begin mSel = newSel; mRes = is_result; end
          if (is_enter) nxt = PH_ISSUE;
        end
      end
      PH_ISSUE: if (!alu_busy) begin eStart = 1; mWaited = 0; nxt = PH_WAIT; end
      PH_WAIT: begin
        mWaited++;
        if (alu_done) nxt = mRes ? PH_RESULT : PH_IDLE;
        else if (mWaited == TO) begin
          eErr = 1; nxt = PH_IDLE; expired = 1;
          mQv = 0; mQent = 0;
        end
      end
      default: nxt = PH_IDLE;
    endcase
    if (QUEUE_ON && mPhase >= PH_ISSUE && !expired) begin
      if (illegal) eErr = 1;
      else if (legal) begin mQv = 1; mQsel = newSel; mQres = is_result; mQent = is_enter; end
      else if (is_enter && mQv) mQent = 1;
    end
    if (nxt == PH_IDLE) begin mSel = 2'b00; mRes = 0; end
    mPhase = nxt;
    eSel  = (nxt == PH_WAIT) ? mSel : 2'b00;
    ePend = (nxt == PH_ARMED) || (nxt == PH_ISSUE);
    eDisp = (nxt == PH_RESULT);
  endtask

  // Every cycle: compare against the model, tally pulses, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!nrst) modelReset();
      checkOutput("cyc alu_start", alu_start, eStart);
      checkOutput("cyc alu_sel", alu_sel, eSel);
      checkOutput("cyc op_pending", op_pending, ePend);
      checkOutput("cyc disp_result", disp_result, eDisp);
      checkOutput("cyc err", err, eErr);
      startCount += int'(alu_start);
      dispCount  += int'(disp_result);
      errCount   += int'(err);
      if (nrst) modelStep();
    end
  end

  initial begin
    // Reset state
    tick(3);
    checkLit("reset alu_start", alu_start, eStart, 0);
    checkLit("reset alu_sel", alu_sel, eSel, 0);
    checkLit("reset op_pending", op_pending, ePend, 0);
    checkLit("reset err", err, eErr, 0);
    nrst = 1'b1;

    // Enter alone in IDLE is ignored
    applyStimulus(3'd0, 0, 0, 1);
    checkLit("idle enter pend", op_pending, ePend, 0);

    // Add with result
    applyStimulus(3'b001, 1, 1, 0);
    checkLit("add pend", op_pending, ePend, 1);
    tick(2);
    applyStimulus(3'd0, 0, 0, 1);
    checkLit("add issue start", alu_start, eStart, 0);
    tick(1);
    checkLit("add start", alu_start, eStart, 1);
    checkLit("add sel", alu_sel, eSel, 2'b01);
    checkLit("add pend cleared", op_pending, ePend, 0);
    tick(5);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    checkLit("add disp", disp_result, eDisp, 1);
    tick(1);
    checkLit("add disp end", disp_result, eDisp, 0);

    // Overwrite while ARMED
    applyStimulus(3'b001, 1, 0, 0);
    applyStimulus(3'b010, 1, 0, 0);
    applyStimulus(3'd0, 0, 0, 1);
    checkLit("ovr pend", op_pending, ePend, 1);
    tick(1);
    checkLit("ovr start", alu_start, eStart, 1);
    checkLit("ovr sel", alu_sel, eSel, 2'b10);
    tick(2);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    checkLit("ovr no disp", disp_result, eDisp, 0);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    tick(1);

    // Illegal opcode, then op+enter held off by busy
    applyStimulus(3'b011, 1, 0, 0);
    checkLit("illegal err", err, eErr, 1);
    checkLit("illegal pend", op_pending, ePend, 0);
    tick(1);
    alu_busy = 1'b1;
    applyStimulus(3'b010, 1, 1, 1);
    checkLit("busy pend", op_pending, ePend, 1);
    tick(9);
    checkLit("busy no start", alu_start, eStart, 0);
    alu_busy = 1'b0;
    tick(1);
    checkLit("busy start", alu_start, eStart, 1);
    checkLit("busy sel", alu_sel, eSel, 2'b10);
    tick(2);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    checkLit("busy disp", disp_result, eDisp, 1);
    tick(2);

    // Watchdog expiry with no done
    applyStimulus(3'b001, 1, 1, 1);
    tick(1);
    checkLit("to start", alu_start, eStart, 1);
    tick(7);
    checkLit("to early err", err, eErr, 0);
    tick(1);
    checkLit("to err", err, eErr, 1);
    checkLit("to sel", alu_sel, eSel, 0);
    tick(2);

    // Done in the expiry cycle wins
    applyStimulus(3'b001, 1, 1, 1);
    tick(1);
    checkLit("tod start", alu_start, eStart, 1);
    tick(7);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    checkLit("tod no err", err, eErr, 0);
    checkLit("tod disp", disp_result, eDisp, 1);
    tick(2);

    // Reset during WAIT
    applyStimulus(3'b010, 1, 1, 1);
    tick(1);
    checkLit("rst start", alu_start, eStart, 1);
    tick(2);
    nrst = 1'b0;
    tick(2);
    checkLit("rst sel", alu_sel, eSel, 0);
    checkLit("rst pend", op_pending, ePend, 0);
    nrst = 1'b1;
    tick(1);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    checkLit("rst no disp", disp_result, eDisp, 0);
    tick(1);

    // Strobe during WAIT: replayed only when the queue is built in
    applyStimulus(3'b001, 1, 1, 1);
    tick(1);
    checkLit("q first start", alu_start, eStart, 1);
    tick(1);
    applyStimulus(3'b010, 1, 0, 1);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    checkLit("q disp", disp_result, eDisp, 1);
    tick(2);
    tick(1);
`ifdef OPCODE_DECODER_QUEUE_EN
    checkLit("q second start", alu_start, eStart, 1);
    checkLit("q second sel", alu_sel, eSel, 2'b10);
`else
    checkLit("q no second start", alu_start, eStart, 0);
    checkLit("q idle pend", op_pending, ePend, 0);
`endif
    tick(2);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    tick(3);

    // Pulse totals over the whole run
    checkOutput("start pulses", 4'(startCount), QUEUE_ON ? 4'd8 : 4'd7);
    checkOutput("disp pulses", 4'(dispCount), 4'd4);
    checkOutput("err pulses", 4'(errCount), 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
